// File: rtl/dump_sequencer_pkg.sv
// Shared types for the debug state-dump sequencer: FSM states, dump sources
// and default word geometry.
package dump_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_LOAD,
    ST_SEND,
    ST_NEXT,
    ST_CHK,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    SRC_PC,
    SRC_REG,
    SRC_MEM
  } src_t;

  localparam int N_DEF          = 8;
  localparam int DATA_SZ_DEF    = 32;
  localparam int BYTES_PER_WORD = DATA_SZ_DEF / N_DEF;

  // Byte counter width able to hold any index 0..bytes-1 plus headroom.
  function automatic int cnt_bits(input int bytes);
    return $clog2(bytes) + 1;
  endfunction

endpackage

// File: rtl/dump_sequencer_word_serializer.sv
// Loads one word and shifts it out MSB-byte-first; a byte leaves only when the
// TX FIFO is not full, so backpressure simply stalls the shift.
module word_serializer #(
  parameter int N       = 8,
  parameter int DATA_SZ = 32,
  parameter int CW      = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DATA_SZ-1:0] load_data,
  input  logic [CW-1:0]      last_idx,
  input  logic               send,
  input  logic               tx_full,
  output logic [N-1:0]       tx_data,
  output logic               wr,
  output logic               last_byte
);

  logic [DATA_SZ-1:0] shreg;
  logic [CW-1:0]      cnt;
  logic [CW-1:0]      lim;

  assign tx_data   = shreg[DATA_SZ-1 -: N];
  assign wr        = send && !tx_full;
  assign last_byte = wr && (cnt == lim);

  // The byte limit is captured with the word so PC and data words may differ in length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
      lim   <= '0;
    end else if (load) begin
      shreg <= load_data;
      cnt   <= '0;
      lim   <= last_idx;
    end else if (wr) begin
      shreg <= shreg << N;
      cnt   <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/dump_sequencer.sv
// Walks PC, register file and a data-memory window, streaming each word to the UART TX FIFO.
// Optional trailing XOR checksum byte when DUMP_CHECKSUM_EN is defined.
module dump_sequencer
  import dump_sequencer_pkg::*;
#(
  parameter int N       = 8,
  parameter int W       = 5,
  parameter int MEM_W   = 5,
  parameter int PC_SZ   = 32,
  parameter int DATA_SZ = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [PC_SZ-1:0]   i_pc,
  input  logic [DATA_SZ-1:0] i_reg_data,
  input  logic [DATA_SZ-1:0] i_mem_data,
  input  logic               i_tx_full,
  output logic [W-1:0]       o_addr,
  output logic [MEM_W-1:0]   o_mem_addr,
  output logic [N-1:0]       o_tx_data,
  output logic               o_wr,
  output logic               o_busy,
  output logic               o_done
);

  localparam int BPW      = DATA_SZ / N;
  localparam int CW       = cnt_bits(BPW);
  localparam int PC_BYTES = ((PC_SZ < DATA_SZ) ? PC_SZ : DATA_SZ) / N;

  state_t             state_q, state_d;
  src_t               src_q;
  logic [W-1:0]       addr_q;
  logic [MEM_W-1:0]   mem_addr_q;
  logic               ser_load;
  logic [DATA_SZ-1:0] ser_data;
  logic [CW-1:0]      ser_last;
  logic               ser_send;
  logic               last_byte;
  logic [DATA_SZ-1:0] pc_word;

  // A short PC is left-aligned so its PC_BYTES bytes are the ones shifted out.
  if (PC_SZ >= DATA_SZ) begin : g_pc_trunc
    assign pc_word = i_pc[DATA_SZ-1:0];
  end else begin : g_pc_align
    assign pc_word = {i_pc, {(DATA_SZ-PC_SZ){1'b0}}};
  end

`ifdef DUMP_CHECKSUM_EN
  logic [N-1:0] chk_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      chk_q <= '0;
    end else if (state_q == ST_IDLE) begin
      chk_q <= '0;
    end else if (state_q == ST_SEND && o_wr) begin
      chk_q <= chk_q ^ o_tx_data;
    end
  end
`endif

  assign ser_send   = (state_q == ST_SEND) || (state_q == ST_CHK);
  assign o_addr     = addr_q;
  assign o_mem_addr = mem_addr_q;
  assign o_busy     = (state_q != ST_IDLE);
  assign o_done     = (state_q == ST_DONE);

  always_comb begin
    state_d  = state_q;
    ser_load = 1'b0;
    ser_data = '0;
    ser_last = CW'(BPW - 1);
    case (state_q)
      ST_IDLE: if (i_start) state_d = ST_WAIT;
      ST_WAIT: state_d = ST_LOAD;
      ST_LOAD: begin
        ser_load = 1'b1;
        state_d  = ST_SEND;
        case (src_q)
          SRC_PC: begin
            ser_data = pc_word;
            ser_last = CW'(PC_BYTES - 1);
          end
          SRC_REG: ser_data = i_reg_data;
          default: ser_data = i_mem_data;
        endcase
      end
      ST_SEND: if (last_byte) state_d = ST_NEXT;
      ST_NEXT: begin
        state_d = ST_WAIT;
        if (src_q == SRC_MEM && mem_addr_q == '1) begin
`ifdef DUMP_CHECKSUM_EN
          state_d  = ST_CHK;
          ser_load = 1'b1;
          ser_data = DATA_SZ'(chk_q) << (DATA_SZ - N);
          ser_last = '0;
`else
          state_d = ST_DONE;
`endif
        end
      end
      ST_CHK:  if (last_byte) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      src_q      <= SRC_PC;
      addr_q     <= '0;
      mem_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && i_start) begin
        src_q      <= SRC_PC;
        addr_q     <= '0;
        mem_addr_q <= '0;
      end else if (state_q == ST_NEXT) begin
        // Counters saturate at their final value; they restart only on the next start.
        case (src_q)
          SRC_PC: begin
            src_q  <= SRC_REG;
            addr_q <= '0;
          end
          SRC_REG: begin
            if (addr_q != '1) begin
              addr_q <= addr_q + W'(1);
            end else begin
              src_q      <= SRC_MEM;
              mem_addr_q <= '0;
            end
          end
          default: if (mem_addr_q != '1) mem_addr_q <= mem_addr_q + MEM_W'(1);
        endcase
      end
    end
  end

  word_serializer #(
    .N       (N),
    .DATA_SZ (DATA_SZ),
    .CW      (CW)
  ) u_ser (
    .clk       (i_clk),
    .rst       (i_reset),
    .load      (ser_load),
    .load_data (ser_data),
    .last_idx  (ser_last),
    .send      (ser_send),
    .tx_full   (i_tx_full),
    .tx_data   (o_tx_data),
    .wr        (o_wr),
    .last_byte (last_byte)
  );

endmodule

// File: tb/tb_dump_sequencer.sv
// Scoreboard bench for dump_sequencer: expected byte stream queued at start, popped per o_wr.
// Covers reset, full dump, backpressure, start-while-busy, mid-dump reset, and DUMP_CHECKSUM_EN.
module tb_dump_sequencer;
  import dump_sequencer_pkg::*;

`ifdef DUMP_CHECKSUM_EN
  localparam int EXP_BYTES = 261;
  localparam int DONE_GAP  = 1;
`else
  localparam int EXP_BYTES = 260;
  localparam int DONE_GAP  = 2;
`endif

  logic        i_clk = 0;
  logic        i_reset = 1;
  logic        i_start = 0;
  logic [31:0] i_pc = 32'h0000_0040;
  logic [31:0] i_reg_data;
  logic [31:0] i_mem_data;
  logic        i_tx_full = 0;
  logic [4:0]  o_addr;
  logic [4:0]  o_mem_addr;
  logic [7:0]  o_tx_data;
  logic        o_wr, o_busy, o_done;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int wr_cnt, done_cnt, busy_falls, last_wr_cyc, done_cyc;
  logic prev_busy = 0;
  logic [7:0] sb_q[$];
  logic [7:0] cap[512];

  dump_sequencer dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .i_pc       (i_pc),
    .i_reg_data (i_reg_data),
    .i_mem_data (i_mem_data),
    .i_tx_full  (i_tx_full),
    .o_addr     (o_addr),
    .o_mem_addr (o_mem_addr),
    .o_tx_data  (o_tx_data),
    .o_wr       (o_wr),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc++;

  assign i_reg_data = {27'd0, o_addr};
  assign i_mem_data = 32'h0000_1000 + {27'd0, o_mem_addr};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (o_wr) begin
      if (sb_q.size() == 0) chk("extra_byte", 32'(o_tx_data), 32'hFFFF_FFFF);
      else chk($sformatf("byte%0d", wr_cnt), 32'(o_tx_data), 32'(sb_q.pop_front()));
      if (wr_cnt < 512) cap[wr_cnt] = o_tx_data;
      wr_cnt++;
      last_wr_cyc = cyc;
    end
    if (o_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (prev_busy && !o_busy) busy_falls++;
    prev_busy = o_busy;
  end

  task automatic push_word(input logic [31:0] w, inout logic [7:0] x);
    for (int b = 3; b >= 0; b--) begin
      sb_q.push_back(w[b*8 +: 8]);
      x = x ^ w[b*8 +: 8];
    end
  endtask

  task automatic start_dump();
    logic [7:0] x;
    x = 8'h00;
    sb_q.delete();
    wr_cnt = 0; done_cnt = 0; busy_falls = 0; last_wr_cyc = 0; done_cyc = 0;
    push_word(i_pc, x);
    for (int i = 0; i < 32; i++) push_word(32'(i), x);
    for (int j = 0; j < 32; j++) push_word(32'h1000 + 32'(j), x);
`ifdef DUMP_CHECKSUM_EN
    sb_q.push_back(x);
`endif
    i_start = 1;
    @(posedge i_clk); #1;
    i_start = 0;
  endtask

  task automatic wait_bytes(input int n);
    int k;
    k = 0;
    while (wr_cnt < n && k < 3000) begin
      @(posedge i_clk); #1;
      k++;
    end
    if (wr_cnt < n) chk("wait_bytes_timeout", 32'(wr_cnt), 32'(n));
  endtask

  task automatic finish_dump(input string tag);
    int k;
    k = 0;
    while ((done_cnt == 0 || o_busy) && k < 5000) begin
      @(posedge i_clk); #1;
      k++;
    end
    repeat (4) @(posedge i_clk);
    #1;
    chk({tag, "_bytes"}, 32'(wr_cnt), 32'(EXP_BYTES));
    chk({tag, "_done"}, 32'(done_cnt), 32'd1);
    chk({tag, "_busy_falls"}, 32'(busy_falls), 32'd1);
    chk({tag, "_sb_left"}, 32'(sb_q.size()), 32'd0);
    chk({tag, "_done_gap"}, 32'(done_cyc - last_wr_cyc), 32'(DONE_GAP));
  endtask

  initial begin
    logic [7:0] spot_exp[12];
    int spot_idx[12];
    spot_exp = '{8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h01,
                 8'h00, 8'h00, 8'h10, 8'h1F};
    spot_idx = '{0, 1, 2, 3, 8, 9, 10, 11, 256, 257, 258, 259};

    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_wr", 32'(o_wr), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_addr", 32'(o_addr), 0);
    chk("rst_mem_addr", 32'(o_mem_addr), 0);
    chk("rst_tx_data", 32'(o_tx_data), 0);
    i_reset = 0;
    repeat (2) @(posedge i_clk);
    #1;

    // Full dump, no backpressure
    start_dump();
    finish_dump("full");
    for (int s = 0; s < 12; s++)
      chk($sformatf("spot%0d", spot_idx[s]), 32'(cap[spot_idx[s]]), 32'(spot_exp[s]));
    chk("end_addr_hold", 32'(o_addr), 32'd31);
    chk("end_mem_addr_hold", 32'(o_mem_addr), 32'd31);
`ifdef DUMP_CHECKSUM_EN
    begin
      logic [7:0] x;
      x = 8'h00;
      for (int i = 0; i < 260; i++) x = x ^ cap[i];
      chk("checksum_byte", 32'(cap[260]), 32'(x));
    end
`endif

    // Backpressure while byte 5 is pending
    start_dump();
    wait_bytes(5);
    i_tx_full = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge i_clk);
      chk("bp_wr_low", 32'(o_wr), 0);
    end
    chk("bp_held_count", 32'(wr_cnt), 32'd5);
    @(posedge i_clk); #1;
    i_tx_full = 0;
    finish_dump("bp");

    // Start pulse while busy is ignored
    start_dump();
    wait_bytes(100);
    i_start = 1;
    @(posedge i_clk); #1;
    i_start = 0;
    finish_dump("busy_start");

    // Asynchronous reset mid-dump
    start_dump();
    wait_bytes(50);
    i_reset = 1;
    #1;
    chk("mid_rst_wr", 32'(o_wr), 0);
    chk("mid_rst_busy", 32'(o_busy), 0);
    chk("mid_rst_addr", 32'(o_addr), 0);
    chk("mid_rst_mem_addr", 32'(o_mem_addr), 0);
    chk("mid_rst_tx_data", 32'(o_tx_data), 0);
    @(posedge i_clk); #1;
    i_reset = 0;
    repeat (10) @(posedge i_clk);
    #1;
    chk("mid_rst_no_done", 32'(done_cnt), 0);
    start_dump();
    finish_dump("after_rst");
    chk("after_rst_pc_byte3", 32'(cap[3]), 32'h40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
